// File: rtl/serializer_8_1_v_pkg.sv
// Shared types and constants for the 8:1 serializer and its bit-select mux.
package serializer_8_1_v_pkg;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned WORD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Select-counter start/end values for each bit order
    localparam logic [SEL_W-1:0] SEL_START_LSB = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_END_LSB   = SEL_W'(7);
    localparam logic [SEL_W-1:0] SEL_START_MSB = SEL_W'(7);
    localparam logic [SEL_W-1:0] SEL_END_MSB   = SEL_W'(0);

    function automatic logic [SEL_W-1:0] sel_start(input logic msb_first);
        return msb_first ? SEL_START_MSB : SEL_START_LSB;
    endfunction

    function automatic logic [SEL_W-1:0] sel_end(input logic msb_first);
        return msb_first ? SEL_END_MSB : SEL_END_LSB;
    endfunction

    // One step toward the end value; only called while short of it, so never wraps
    function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] sel,
                                                  input logic             msb_first);
        return msb_first ? SEL_W'(sel - SEL_W'(1)) : SEL_W'(sel + SEL_W'(1));
    endfunction

endpackage

// File: rtl/MUX_8_1_v__behavior.sv
// Behavioural 8:1 mux: returns the data bit addressed by sel.
module MUX_8_1_v__behavior
    import serializer_8_1_v_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    input  logic [SEL_W-1:0]  sel,
    output logic              y
);

    always_comb begin
        y = 1'b0;
        case (sel)
            3'd0: y = data[0];
            3'd1: y = data[1];
            3'd2: y = data[2];
            3'd3: y = data[3];
            3'd4: y = data[4];
            3'd5: y = data[5];
            3'd6: y = data[6];
            3'd7: y = data[7];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/serializer_8_1_v.sv
// 8-bit parallel-to-serial converter with valid/ready intake, flush and
// selectable bit order; bits are picked from the held word by an 8:1 mux.
module serializer_8_1_v
    import serializer_8_1_v_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WORD_W-1:0] i_code,
    input  logic              i_flush,
    output logic [SEL_W-1:0]  o_sel_code,
    output logic              o_f,
    output logic              o_f_valid,
    output logic              o_first,
    output logic              o_last,
    output logic              o_busy
);

    localparam logic [SEL_W-1:0] SEL_START = sel_start(MSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_END   = sel_end(MSB_FIRST);

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_next;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  sel_next;
    logic              ready_en_q;
    logic              accept_c;

    // Registered state; ready_en_q keeps o_ready low through reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            word_q     <= '0;
            sel_q      <= SEL_START;
            ready_en_q <= 1'b0;
        end else begin
            state      <= state_next;
            word_q     <= word_next;
            sel_q      <= sel_next;
            ready_en_q <= 1'b1;
        end
    end

    assign o_busy     = (state == SHIFT);
    assign o_f_valid  = (state == SHIFT);
    assign o_first    = (state == SHIFT) && (sel_q == SEL_START);
    assign o_last     = (state == SHIFT) && (sel_q == SEL_END);
    assign o_ready    = ready_en_q && ((state == IDLE) || o_last);
    assign o_sel_code = sel_q;
    assign accept_c   = i_valid && o_ready && !i_flush;

    // Next state: flush beats accept; the word is cleared on every return to
    // IDLE so the mux output reads 0 there.
    always_comb begin
        state_next = state;
        word_next  = word_q;
        sel_next   = sel_q;
        if (i_flush) begin
            state_next = IDLE;
            word_next  = '0;
            sel_next   = SEL_START;
        end else if (accept_c) begin
            state_next = SHIFT;
            word_next  = i_code;
            sel_next   = SEL_START;
        end else begin
            case (state)
                SHIFT: begin
                    if (o_last) begin
                        state_next = IDLE;
                        word_next  = '0;
                        sel_next   = SEL_START;
                    end else begin
                        sel_next = sel_step(sel_q, MSB_FIRST);
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    MUX_8_1_v__behavior u_mux (
        .data (word_q),
        .sel  (sel_q),
        .y    (o_f)
    );

endmodule

// File: doc/serializer_8_1_v.md
SERIALIZER_8_1_V -- requirements
Module: serializer_8_1_v

Interface
REQ-001 The module SHALL have parameter MSB_FIRST, default 0; when 0 it emits bit 0 first, and when 1 it emits bit 7 first.
REQ-002 i_clk  input  1  Single clock; all state SHALL change on the rising edge.
REQ-003 i_rst  input  1  Reset, synchronous and active-high.
REQ-004 i_valid  input  1  Upstream word-valid signal.
REQ-005 o_ready  output  1  High when the block accepts a word this cycle.
REQ-006 i_code  input  8  Parallel word, sampled on an accept.
REQ-007 i_flush  input  1  Synchronous abort of the current word.
REQ-008 o_sel_code  output  3  Select code currently applied to the internal 8:1 mux.
REQ-009 o_f  output  1  Serial data bit, equal to the held word indexed by o_sel_code.
REQ-010 o_f_valid  output  1  High when o_f carries a real bit.
REQ-011 o_first  output  1  High with the first bit of a word.
REQ-012 o_last  output  1  High with the eighth bit of a word.
REQ-013 o_busy  output  1  High when the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have two states:
- IDLE
- SHIFT
REQ-015 An accept SHALL occur in any cycle where i_valid=1, o_ready=1 and i_flush=0.
REQ-016 o_ready SHALL equal (state==IDLE) OR (state==SHIFT AND o_last=1), and SHALL be combinational from registered state only.
REQ-017 On an accept, the block SHALL register i_code into a word register, load the select counter with 3'd0 (MSB_FIRST=0) or 3'd7 (MSB_FIRST=1), and enter SHIFT.
REQ-018 In SHIFT, o_f_valid SHALL be 1, and the select counter SHALL step by one each cycle: increment when MSB_FIRST=0, decrement when MSB_FIRST=1.
REQ-019 Latency: the first bit of a word accepted in cycle N SHALL appear in cycle N+1, and its last bit in cycle N+8.
REQ-020 o_first SHALL be high when the counter equals its start value in SHIFT; o_last SHALL be high when it equals its end value (7 or 0) in SHIFT.
REQ-021 Back-to-back: an accept during the o_last cycle SHALL reload the word and counter, so that the next word's first bit follows in the next cycle with no bubble.
REQ-022 If the o_last cycle has no accept, the FSM SHALL return to IDLE.
REQ-023 The counter SHALL NOT wrap within a word; 3-bit modular stepping SHALL be used only between the start and end values.
REQ-024 i_valid while o_ready=0 SHALL be ignored; the word register SHALL be unchanged.
REQ-025 i_flush=1 SHALL force IDLE in the next cycle and discard the held word.
REQ-026 Flush SHALL win over a simultaneous accept.
REQ-027 In IDLE, o_f and o_f_valid SHALL be 0 and o_sel_code SHALL hold its start value.
REQ-028 o_f SHALL be combinational from the word register and the select counter only, never directly from i_code.

Reset
REQ-029 While i_rst=1, the block SHALL hold state=IDLE, word register=8'h00, and counter=start value.
REQ-030 Output values during reset SHALL be:
- o_ready=0 during reset
- o_ready=1 from the first cycle after release
- o_f=0, o_f_valid=0, o_first=0, o_last=0, o_busy=0
REQ-031 Reset asserted mid-word SHALL abandon the word, with no further o_f_valid pulses.
REQ-032 Reset SHALL have priority over flush and accept.

Structure
REQ-033 A shared package SHALL hold:
- the state enumeration (IDLE, SHIFT)
- SEL_W=3
- WORD_W=8
- the start and end select constants for each MSB_FIRST value
REQ-034 Bit selection SHALL be performed by instantiating the team's existing 8:1 behavioural mux sub-module MUX_8_1_v__behavior, driven by the word register and o_sel_code; no second mux implementation is permitted.

Verification
REQ-035 The bench SHALL cover a reset check: hold i_rst for 3 cycles, then release; all outputs are 0 during reset, and o_ready=1 from the first cycle after release.
REQ-036 The bench SHALL cover a single LSB-first word:
- Stimulus: MSB_FIRST=0, accept 8'hA5.
- Required response: o_f = 1,0,1,0,0,1,0,1 over cycles N+1..N+8.
- o_first only at N+1 and o_last only at N+8.
REQ-037 The bench SHALL cover back-to-back words:
- Stimulus: accept 8'hFF, then hold i_valid with 8'h0F.
- Required response: 8'h0F is accepted in the o_last cycle, and o_f_valid stays high for 16 consecutive cycles.
- o_f sequence: eight 1s, then 1,1,1,1,0,0,0,0.
REQ-038 The bench SHALL cover stall and ignore:
- Stimulus: present 8'h3C mid-word with o_ready=0.
- Required response: the word register is unchanged, and 8'h3C is taken only at o_last.
REQ-039 The bench SHALL cover flush and reset mid-word:
- i_flush during bit 3 (even with i_valid=1): o_f_valid=0 next cycle, and IDLE.
- i_rst during bit 5: the same outcome, with the word register reading 8'h00.
REQ-040 The bench SHALL cover MSB-first operation:
- Stimulus: MSB_FIRST=1, accept 8'h01.
- Required response: o_sel_code = 7,6,...,0, and o_f = 0,0,0,0,0,0,0,1.
